// File: rtl/custom_mac_operand_buffer_if.sv
// rtl/custom_mac_operand_buffer_if.sv - operand write / result handshake bus of the MAC operand buffer
//  master: drives operand bytes, lane selects, write enables, start requests and result ready
//  slave : the operand buffer; returns per-lane results, valid, busy and the sticky overflow flag
//  mem_data_i      operand byte shared by all lanes
//  demux_sel_i     2-bit entry index per lane, lane i at [2i+1:2i]
//  weight_en_i     per-lane weight write enable
//  feature_en_i    per-lane feature write enable
//  acc_en_i        per-lane accumulate (1) / clear (0) choice, sampled at lane start
//  buff_use_i      per-lane start request, rising edge triggers a MAC run
//  result_o        lane i result at [ACC_W*i +: ACC_W]
//  result_valid_o  per-lane result valid
//  result_ready_i  per-lane result accept
//  busy_o          per-lane busy (MAC or DONE)
//  overflow_o      sticky protocol error
interface custom_mac_operand_buffer_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 20
);
    logic [DATA_W-1:0]      mem_data_i;
    logic [2*LANES-1:0]     demux_sel_i;
    logic [LANES-1:0]       weight_en_i;
    logic [LANES-1:0]       feature_en_i;
    logic [LANES-1:0]       acc_en_i;
    logic [LANES-1:0]       buff_use_i;
    logic [LANES*ACC_W-1:0] result_o;
    logic [LANES-1:0]       result_valid_o;
    logic [LANES-1:0]       result_ready_i;
    logic [LANES-1:0]       busy_o;
    logic                   overflow_o;

    modport master (
        output mem_data_i, demux_sel_i, weight_en_i, feature_en_i, acc_en_i, buff_use_i,
        output result_ready_i,
        input  result_o, result_valid_o, busy_o, overflow_o
    );

    modport slave (
        input  mem_data_i, demux_sel_i, weight_en_i, feature_en_i, acc_en_i, buff_use_i,
        input  result_ready_i,
        output result_o, result_valid_o, busy_o, overflow_o
    );
endinterface

// File: rtl/custom_mac_operand_buffer.sv
// rtl/custom_mac_operand_buffer.sv - per-lane operand capture and serial 4-tap multiply-accumulate
//  clk  rising-edge clock
//  rst  synchronous active-high reset
//  bus  custom_mac_operand_buffer_if.slave: operand writes, start requests, result handshake
module custom_mac_operand_buffer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int TAPS   = 4,
    parameter int ACC_W  = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    custom_mac_operand_buffer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } lane_state_t;

    lane_state_t         state_q   [LANES];
    lane_state_t         state_d   [LANES];
    logic [1:0]          tap_q     [LANES];
    logic [ACC_W-1:0]    acc_q     [LANES];
    logic [ACC_W-1:0]    result_q  [LANES];
    logic [ACC_W-1:0]    mac_sum   [LANES];
    logic [2*DATA_W-1:0] product   [LANES];
    logic [DATA_W-1:0]   weight_q  [LANES][TAPS];
    logic [DATA_W-1:0]   feature_q [LANES][TAPS];
    logic [LANES-1:0]    buff_use_q;
    logic [LANES-1:0]    start;
    logic [LANES-1:0]    write_req;
    logic [LANES-1:0]    proto_err;
    logic                overflow_q;

    assign start     = bus.buff_use_i & ~buff_use_q;
    assign write_req = bus.weight_en_i | bus.feature_en_i;

    // Product is formed at full 2*DATA_W width, then zero-extended into the wrapping accumulator.
    always_comb begin
        proto_err = '0;
        for (int i = 0; i < LANES; i++) begin
            product[i]   = {{DATA_W{1'b0}}, weight_q[i][tap_q[i]]} *
                           {{DATA_W{1'b0}}, feature_q[i][tap_q[i]]};
            mac_sum[i]   = acc_q[i] + ACC_W'(product[i]);
            proto_err[i] = (start[i] && (state_q[i] != S_IDLE)) ||
                           (write_req[i] && (state_q[i] == S_MAC));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (rst) begin
                state_q[i] <= S_IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:  if (start[i]) state_d[i] = S_MAC;
                S_MAC:   if (tap_q[i] == 2'd3) state_d[i] = S_DONE;
                S_DONE:  if (bus.result_ready_i[i]) state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buff_use_q <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                tap_q[i]    <= '0;
                acc_q[i]    <= '0;
                result_q[i] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    weight_q[i][t]  <= '0;
                    feature_q[i][t] <= '0;
                end
            end
        end else begin
            // Edge history tracks the raw input, including requests that get ignored.
            buff_use_q <= bus.buff_use_i;
            if (|proto_err) begin
                overflow_q <= 1'b1;
            end
            for (int i = 0; i < LANES; i++) begin
                case (state_q[i])
                    S_IDLE: begin
                        if (start[i]) begin
                            tap_q[i] <= 2'd0;
                            acc_q[i] <= bus.acc_en_i[i] ? result_q[i] : '0;
                        end
                    end
                    S_MAC: begin
                        acc_q[i] <= mac_sum[i];
                        tap_q[i] <= tap_q[i] + 2'd1;
                        if (tap_q[i] == 2'd3) begin
                            result_q[i] <= mac_sum[i];
                        end
                    end
                    default: ;
                endcase
                // Operands are frozen while the lane is accumulating; a write in the
                // start cycle still lands because the lane is IDLE at that edge.
                if (state_q[i] != S_MAC) begin
                    if (bus.weight_en_i[i]) begin
                        weight_q[i][bus.demux_sel_i[2*i +: 2]] <= bus.mem_data_i;
                    end
                    if (bus.feature_en_i[i]) begin
                        feature_q[i][bus.demux_sel_i[2*i +: 2]] <= bus.mem_data_i;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.result_o       = '0;
        bus.result_valid_o = '0;
        bus.busy_o         = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.result_o[ACC_W*i +: ACC_W] = result_q[i];
            bus.result_valid_o[i]          = (state_q[i] == S_DONE);
            bus.busy_o[i]                  = (state_q[i] != S_IDLE);
        end
    end

    assign bus.overflow_o = overflow_q;
endmodule
